// File: rtl/peripheral_msi_uart_rx.sv
// 8N1 serial receiver for the MSI UART line, with a small receive FIFO on a valid/ready port.
// Framing errors and overruns are reported as single-cycle pulses.
module peripheral_msi_uart_rx #(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               mclk,
    input  logic                               puc_rst,
    input  logic                               smclk_en,
    input  logic                               msi_txd,
    output logic [7:0]                         rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_level,
    output logic                               frame_err,
    output logic                               overrun,
    output logic [1:0]                         dbg_state
);

    localparam int CW   = $clog2(BAUD_DIV);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam int HALF = BAUD_DIV / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Handshake: a byte leaves the FIFO on any mclk edge where rx_valid & rx_ready;
    // rx_valid/rx_data hold steady until that happens, rx_ready is ignored while empty.

    state_t          state_q, state_d;
    logic            sync1_q, s_q, sprev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            push;
    logic            ferr_d, ferr_q;
    logic            ovr_d, ovr_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [LW-1:0]   level_q, level_d;
    logic            full, pop, wr_en;

    logic            fall;
    logic            half_done, bit_done;

    assign fall      = sprev_q & ~s_q;
    assign half_done = smclk_en && (cnt_q == CW'(HALF - 1));
    assign bit_done  = smclk_en && (cnt_q == CW'(BAUD_DIV - 1));

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            s_q     <= 1'b1;
            sprev_q <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= msi_txd;
            s_q     <= sync1_q;
            sprev_q <= s_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (s_q) begin
                        state_d = IDLE;
                    end else begin
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end else if (smclk_en) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = s_q;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else if (smclk_en) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (s_q) push = 1'b1;
                    else     ferr_d = 1'b1;
                end else if (smclk_en) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the same cycle pops, so no byte is lost then.
    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign pop   = rx_valid & rx_ready;
    assign wr_en = push & (~full | pop);
    assign ovr_d = push & full & ~pop;

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop)      level_d = level_q + LW'(1);
        else if (!wr_en && pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (pop)   rd_q <= rd_q + PW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge mclk) begin
        if (wr_en) mem_q[wr_q] <= shift_q;
    end

    assign rx_valid  = (level_q != '0);
    assign rx_data   = rx_valid ? mem_q[rd_q] : 8'h00;
    assign rx_level  = level_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign dbg_state = state_q;

endmodule
